// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Upper op bit selects the divide family.
  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV (low bit clear) treat their operands as two's complement.
  function automatic logic opIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Arithmetic core of the multiply/divide unit: operand magnitudes, the
// shift-add / restoring shift-subtract iteration and the final sign fix.
// Optional build macro MULDIV_EARLY_TERM_EN: report when a multiply has no
// multiplier bits left so the controller may leave CALC early.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             earlyDone_o,
  output logic [WIDTH-1:0] resHi_o,
  output logic [WIDTH-1:0] resLo_o
);

  // Multiply: acc accumulates the shifted multiplicand held in mcand.
  // Divide: acc holds {remainder, quotient/dividend}, mcand low half the divisor.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               isDiv_q, isDiv_d;
  logic               negLo_q, negLo_d;
  logic               negHi_q, negHi_d;

  logic               signA, signB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] prod;

  // Load operand magnitudes and sign info, or perform one iteration step.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    isDiv_d  = isDiv_q;
    negLo_d  = negLo_q;
    negHi_d  = negHi_q;
    signA    = opIsSigned(op_i) & a_i[WIDTH-1];
    signB    = opIsSigned(op_i) & b_i[WIDTH-1];
    magA     = signA ? -a_i : a_i;
    magB     = signB ? -b_i : b_i;
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = shifted - {1'b0, mcand_q[WIDTH-1:0]};
    if (load_i) begin
      isDiv_d = opIsDiv(op_i);
      if (opIsDiv(op_i)) begin
        acc_d    = {{WIDTH{1'b0}}, magA};
        mcand_d  = {{WIDTH{1'b0}}, magB};
        mplier_d = '0;
        negLo_d  = signA ^ signB;
        negHi_d  = signA;
      end else begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, magA};
        mplier_d = magB;
        negLo_d  = signA ^ signB;
        negHi_d  = signA ^ signB;
      end
    end else if (step_i) begin
      if (isDiv_q) begin
        if (!diff[WIDTH]) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  // Sign correction of the magnitude result into HI/LO form.
  always_comb begin
    prod = negLo_q ? -acc_q : acc_q;
    if (isDiv_q) begin
      resLo_o = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      resHi_o = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      resLo_o = prod[WIDTH-1:0];
      resHi_o = prod[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign earlyDone_o = ~isDiv_q && ((mplier_q >> 1) == '0);
`else
  assign earlyDone_o = 1'b0;
`endif

  // Datapath register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      isDiv_q  <= 1'b0;
      negLo_q  <= 1'b0;
      negHi_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      isDiv_q  <= isDiv_d;
      negLo_q  <= negLo_d;
      negHi_q  <= negHi_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: FSM, iteration
// counter, start/busy/done handshake and move-to-HI/LO writes.
// Optional build macro MULDIV_EARLY_TERM_EN: data-dependent multiply latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               divZero_q, divZero_d;
  logic               load, step, earlyDone;
  logic [WIDTH-1:0]   resHi, resLo;

  muldiv_datapath #(.WIDTH(WIDTH)) uDatapath (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .earlyDone_o (earlyDone),
    .resHi_o     (resHi),
    .resLo_o     (resLo)
  );

  // Next-state logic: accept requests, count iterations, commit results.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divZero_d = divZero_q;
    load      = 1'b0;
    step      = 1'b0;
    if (state_q == IDLE || state_q == DONE) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (opIsDiv(op) && (b == '0)) begin
            divZero_d = 1'b1;
            state_d   = DONE;
          end else begin
            divZero_d = 1'b0;
            cnt_d     = '0;
            load      = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q == CNT_W'(WIDTH - 1)) || earlyDone) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = resHi;
        lo_d    = resLo;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign div_zero = divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a transaction-level model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat, bc;
  logic sawDone;

  logic [W-1:0] mHi, mLo, mPendHi, mPendLo;
  logic         mDz, mDone, mValid;
  int           mRemain;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of an operation, {HI, LO}.
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, rm;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        q  = sx / sy;
        rm = sx % sy;
        r  = {rm[31:0], q[31:0]};
      end
      default:  r = {x % y, x / y};
    endcase
    return r;
  endfunction

  // Number of cycles busy stays high after acceptance.
  function automatic int refBusy(input logic [1:0] o, input logic [W-1:0] y);
    logic [W-1:0] mag;
    int bits;
    mag  = (o == OP_MULT && y[W-1]) ? -y : y;
    bits = 0;
    for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
    if (bits == 0) bits = 1;
    return (EARLY && !o[1]) ? bits + 1 : W + 1;
  endfunction

  // Transaction-level model of the unit, advanced on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      mValid  <= 1'b1;
      mHi     <= '0;
      mLo     <= '0;
      mDz     <= 1'b0;
      mDone   <= 1'b0;
      mRemain <= 0;
    end else begin
      mDone <= 1'b0;
      if (mRemain > 0) begin
        mRemain <= mRemain - 1;
        if (mRemain == 1) begin
          mHi   <= mPendHi;
          mLo   <= mPendLo;
          mDone <= 1'b1;
        end
      end else begin
        if (hi_we) mHi <= wdata;
        if (lo_we) mLo <= wdata;
        if (!mDone && start) begin
          if (op[1] && b == '0) begin
            mDz   <= 1'b1;
            mDone <= 1'b1;
          end else begin
            mDz     <= 1'b0;
            mRemain <= refBusy(op, b);
            {mPendHi, mPendLo} <= refResult(op, a, b);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (mValid === 1'b1) begin
        checkOutput("model.busy", busy, 64'(mRemain > 0));
        checkOutput("model.done", done, mDone);
        checkOutput("model.div_zero", div_zero, mDz);
        checkOutput("model.hi", hi, mHi);
        checkOutput("model.lo", lo, mLo);
      end
    end
  endtask

  // Samples at the current negedge onward until done, bounded.
  task automatic waitDone(output int cycles, output int busyCycles);
    cycles = -1;
    busyCycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busyCycles++;
      if (done) begin
        cycles = i + 1;
        break;
      end
      @(negedge clk);
    end
    if (cycles < 0) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int cycles, output int busyCycles);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    waitDone(cycles, busyCycles);
  endtask

  task automatic writeHiLo(input logic [W-1:0] h, input logic [W-1:0] l);
    @(negedge clk);
    hi_we = 1'b1; wdata = h;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = l;
    @(negedge clk);
    lo_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; a = '0; b = '0; wdata = '0;
    fork
      compareLoop();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.div_zero", div_zero, 0);
    checkOutput("reset.hi", hi, 0);
    checkOutput("reset.lo", lo, 0);
    reset = 1'b0;

    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
    checkOutput("mult.hi", hi, 32'hFFFFFFFF);
    checkOutput("mult.lo", lo, 32'hFFFFFFEB);
    checkOutput("mult.latency", lat, EARLY ? 5 : 34);
    checkOutput("mult.busyCycles", bc, EARLY ? 4 : 33);

    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checkOutput("multu.hi", hi, 32'hFFFFFFFE);
    checkOutput("multu.lo", lo, 32'h00000001);
    checkOutput("multu.latency", lat, 34);

    applyStimulus(OP_DIV, -32'sd7, 32'd2, lat, bc);
    checkOutput("div.lo", lo, 32'hFFFFFFFD);
    checkOutput("div.hi", hi, 32'hFFFFFFFF);
    checkOutput("div.latency", lat, 34);

    applyStimulus(OP_DIVU, 32'd7, 32'd2, lat, bc);
    checkOutput("divu.lo", lo, 32'd3);
    checkOutput("divu.hi", hi, 32'd1);

    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checkOutput("divMin.lo", lo, 32'h80000000);
    checkOutput("divMin.hi", hi, 32'h0);
    checkOutput("divMin.div_zero", div_zero, 0);

    writeHiLo(32'h11, 32'h22);
    applyStimulus(OP_DIV, 32'd5, 32'd0, lat, bc);
    checkOutput("divZero.latency", lat, 1);
    checkOutput("divZero.busyCycles", bc, 0);
    checkOutput("divZero.flag", div_zero, 1);
    checkOutput("divZero.hi", hi, 32'h11);
    checkOutput("divZero.lo", lo, 32'h22);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, lat, bc);
    checkOutput("afterZero.div_zero", div_zero, 0);
    checkOutput("afterZero.lo", lo, 32'd14);
    checkOutput("afterZero.hi", hi, 32'd2);

    applyStimulus(OP_MULTU, 32'd5, 32'd3, lat, bc);
    checkOutput("small.lo", lo, 32'd15);
    checkOutput("small.hi", hi, 32'd0);
    checkOutput("small.latency", lat, EARLY ? 4 : 34);

    applyStimulus(OP_MULT, 32'd9, 32'd0, lat, bc);
    checkOutput("zeroMul.lo", lo, 32'd0);
    checkOutput("zeroMul.latency", lat, EARLY ? 3 : 34);

    applyStimulus(OP_MULT, -32'sd5, -32'sd3, lat, bc);
    checkOutput("negNeg.lo", lo, 32'd15);
    checkOutput("negNeg.hi", hi, 32'd0);

    @(negedge clk);
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    waitDone(lat, bc);
    checkOutput("busyIgnore.lo", lo, 32'd42);
    checkOutput("busyIgnore.hi", hi, 32'd0);

    @(negedge clk);
    op = OP_MULT; a = 32'd123; b = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.done", done, 0);
    checkOutput("midReset.hi", hi, 0);
    checkOutput("midReset.lo", lo, 0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", sawDone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
